// File: rtl/traffic_conflict_monitor_pkg.sv
// Shared types and helpers for the traffic conflict monitor: fault causes,
// monitor states and small lamp-decoding functions.
package traffic_conflict_monitor_pkg;

    typedef enum logic [2:0] {
        NONE         = 3'd0,
        CONFLICT     = 3'd1,
        MULTI_LAMP   = 3'd2,
        DARK         = 3'd3,
        SHORT_YELLOW = 3'd4,
        SKIP_YELLOW  = 3'd5
    } fault_e;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        PENDING = 2'd1,
        FAULT   = 2'd2,
        RECOVER = 2'd3
    } state_e;

    // Lamp vectors are {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;

    function automatic logic [1:0] lamp_count(input logic [2:0] lamps);
        return {1'b0, lamps[0]} + {1'b0, lamps[1]} + {1'b0, lamps[2]};
    endfunction

    function automatic fault_e pick_cause(input logic conflict,
                                          input logic skip_yellow,
                                          input logic short_yellow,
                                          input logic multi_lamp,
                                          input logic dark);
        if (conflict) begin
            return CONFLICT;
        end else if (skip_yellow) begin
            return SKIP_YELLOW;
        end else if (short_yellow) begin
            return SHORT_YELLOW;
        end else if (multi_lamp) begin
            return MULTI_LAMP;
        end else if (dark) begin
            return DARK;
        end else begin
            return NONE;
        end
    endfunction

endpackage

// File: rtl/traffic_conflict_monitor_yellow_timer.sv
// Per-head lamp history: flags a green->red skip and a yellow phase that was
// shorter than MIN_YELLOW samples when the head turns red.
module yellow_timer
    import traffic_conflict_monitor_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] lamps,
    output logic       skip_yellow,
    output logic       short_yellow
);

    logic       prev_green_r;
    logic       prev_yellow_r;
    logic [3:0] count_r;
    logic       red_only;

    // Previous-sample lamps and saturating yellow run length
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_green_r  <= 1'b0;
            prev_yellow_r <= 1'b0;
            count_r       <= 4'd0;
        end else begin
            prev_green_r  <= lamps[0];
            prev_yellow_r <= lamps[1];
            if (lamps[1]) begin
                count_r <= (count_r == 4'hF) ? count_r : count_r + 4'd1;
            end else begin
                count_r <= 4'd0;
            end
        end
    end

    // History registers are zero after reset, so nothing fires on the first sample
    assign red_only     = (lamps == LAMP_RED);
    assign skip_yellow  = prev_green_r & red_only;
    assign short_yellow = prev_yellow_r & red_only & (count_r < 4'(MIN_YELLOW));

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Conflict monitor for a three-head intersection with turn arrow and
// pedestrian lamps; latches the first fault and requests all-red flash.
module traffic_conflict_monitor
    import traffic_conflict_monitor_pkg::*;
#(
    parameter int unsigned PERSIST        = 2,
    parameter int unsigned MIN_YELLOW     = 3,
    parameter int unsigned RECOVER_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] head1,
    input  logic [2:0] head2,
    input  logic [2:0] head3,
    input  logic       turn,
    input  logic       white,
    input  logic       orange,
    input  logic       clear_fault,
    output logic       fault,
    output logic       flash,
    output logic [2:0] fault_code
);

    state_e     state_r, state_n;
    fault_e     code_r, code_n;
    logic [3:0] persist_cnt_r, persist_cnt_n;
    logic [3:0] recover_cnt_r, recover_cnt_n;
    logic       latched_n;

    logic       perm1, perm2, perm3;
    logic       conflict, multi_lamp, dark, static_viol, all_red;
    logic [2:0] skip, short_y;
    logic       ev_skip, ev_short, static_latch;

    assign perm1 = head1[1] | head1[0];
    assign perm2 = head2[1] | head2[0];
    assign perm3 = head3[1] | head3[0];

    assign conflict   = (perm1 & (perm2 | perm3 | turn)) | (turn & perm2) |
                        (white & (perm1 | perm2 | perm3 | turn));
    assign multi_lamp = (lamp_count(head1) > 2'd1) | (lamp_count(head2) > 2'd1) |
                        (lamp_count(head3) > 2'd1) | (white & orange);
    assign dark       = (head1 == 3'b000) | (head2 == 3'b000) | (head3 == 3'b000) |
                        ~(white | orange);
    assign static_viol = conflict | multi_lamp | dark;
    assign all_red    = (head1 == LAMP_RED) & (head2 == LAMP_RED) & (head3 == LAMP_RED) &
                        ~turn & ~white & orange;

    yellow_timer #(.MIN_YELLOW(MIN_YELLOW)) u_timer1 (
        .clock(clock), .reset(reset), .lamps(head1),
        .skip_yellow(skip[0]), .short_yellow(short_y[0])
    );
    yellow_timer #(.MIN_YELLOW(MIN_YELLOW)) u_timer2 (
        .clock(clock), .reset(reset), .lamps(head2),
        .skip_yellow(skip[1]), .short_yellow(short_y[1])
    );
    yellow_timer #(.MIN_YELLOW(MIN_YELLOW)) u_timer3 (
        .clock(clock), .reset(reset), .lamps(head3),
        .skip_yellow(skip[2]), .short_yellow(short_y[2])
    );

    // Next-state, persistence/recovery counting and fault-cause selection
    always_comb begin
        state_n       = state_r;
        code_n        = code_r;
        persist_cnt_n = persist_cnt_r;
        recover_cnt_n = recover_cnt_r;
        ev_skip       = 1'b0;
        ev_short      = 1'b0;
        static_latch  = 1'b0;
        case (state_r)
            MONITOR, PENDING: begin
                ev_skip  = |skip;
                ev_short = |short_y;
                if (static_viol) begin
                    persist_cnt_n = persist_cnt_r + 4'd1;
                    static_latch  = (({1'b0, persist_cnt_r} + 5'd1) >= 5'(PERSIST));
                    state_n       = PENDING;
                end else begin
                    persist_cnt_n = 4'd0;
                    state_n       = MONITOR;
                end
                // Event faults bypass persistence; static causes compete only once persistent
                if (static_latch | ev_skip | ev_short) begin
                    state_n       = FAULT;
                    persist_cnt_n = 4'd0;
                    code_n        = pick_cause(static_latch & conflict, ev_skip, ev_short,
                                               static_latch & multi_lamp, static_latch & dark);
                end else begin
                    code_n = code_r;
                end
            end
            FAULT: begin
                if (clear_fault & all_red) begin
                    state_n       = RECOVER;
                    recover_cnt_n = 4'd0;
                end else begin
                    state_n = FAULT;
                end
            end
            RECOVER: begin
                if (!all_red) begin
                    state_n       = FAULT;
                    recover_cnt_n = 4'd0;
                end else if (({1'b0, recover_cnt_r} + 5'd1) >= 5'(RECOVER_CYCLES)) begin
                    state_n       = MONITOR;
                    recover_cnt_n = 4'd0;
                    code_n        = NONE;
                end else begin
                    recover_cnt_n = recover_cnt_r + 4'd1;
                end
            end
            default: begin
                state_n       = MONITOR;
                code_n        = NONE;
                persist_cnt_n = 4'd0;
                recover_cnt_n = 4'd0;
            end
        endcase
        latched_n = (state_n == FAULT) || (state_n == RECOVER);
    end

    // State, counters and registered outputs; flash is requested while held in reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= MONITOR;
            code_r        <= NONE;
            persist_cnt_r <= 4'd0;
            recover_cnt_r <= 4'd0;
            fault         <= 1'b0;
            flash         <= 1'b1;
        end else begin
            state_r       <= state_n;
            code_r        <= code_n;
            persist_cnt_r <= persist_cnt_n;
            recover_cnt_r <= recover_cnt_n;
            fault         <= latched_n;
            flash         <= latched_n;
        end
    end

    assign fault_code = code_r;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: an abstract rule model is
// compared every falling edge, plus literal expectations at key points.
module tb_traffic_conflict_monitor;

    localparam int PERSIST        = 2;
    localparam int MIN_YELLOW     = 3;
    localparam int RECOVER_CYCLES = 4;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, OFF = 3'b000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] head1 = R, head2 = R, head3 = R;
    logic       turn = 1'b0, white = 1'b0, orange = 1'b1, clear_fault = 1'b0;
    logic       fault, flash;
    logic [2:0] fault_code;

    int checks = 0;
    int passed = 0;
    bit cmp_en = 1'b0;

    // abstract model state
    int         m_mode;       // 0 watching, 1 latched, 2 clearing
    int         m_streak, m_run;
    bit         m_hist;
    logic [2:0] m_prev [3];
    int         m_yrun [3];
    int         exp_fault, exp_flash, exp_code;

    traffic_conflict_monitor #(
        .PERSIST(PERSIST), .MIN_YELLOW(MIN_YELLOW), .RECOVER_CYCLES(RECOVER_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .head1(head1), .head2(head2), .head3(head3),
        .turn(turn), .white(white), .orange(orange), .clear_fault(clear_fault),
        .fault(fault), .flash(flash), .fault_code(fault_code)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_streak = 0; m_run = 0; m_hist = 1'b0;
        for (int i = 0; i < 3; i++) begin m_prev[i] = 3'b000; m_yrun[i] = 0; end
        exp_fault = 0; exp_flash = 1; exp_code = 0;
    endtask

    task automatic model_edge();
        logic [2:0] cur [3];
        bit p [3];
        bit conf, multi, dk, allred, skp, shrt;
        int causes [5];
        int codes [5];
        cur = '{head1, head2, head3};
        codes = '{1, 5, 4, 2, 3};
        for (int i = 0; i < 3; i++) p[i] = cur[i][1] || cur[i][0];
        conf = (p[0] && (p[1] || p[2] || turn)) || (turn && p[1]) ||
               (white && (p[0] || p[1] || p[2] || turn));
        multi = white && orange;
        dk = !white && !orange;
        skp = 1'b0; shrt = 1'b0;
        allred = !turn && !white && orange;
        for (int i = 0; i < 3; i++) begin
            if ($countones(cur[i]) > 1) multi = 1'b1;
            if (cur[i] == OFF) dk = 1'b1;
            if (cur[i] != R) allred = 1'b0;
            if (m_hist && cur[i] == R && m_prev[i][0]) skp = 1'b1;
            if (m_hist && cur[i] == R && m_prev[i][1] && m_yrun[i] < MIN_YELLOW) shrt = 1'b1;
        end
        if (m_mode == 0) begin
            m_streak = (conf || multi || dk) ? m_streak + 1 : 0;
            if (m_streak < PERSIST) begin conf = 1'b0; multi = 1'b0; dk = 1'b0; end
            causes = '{int'(conf), int'(skp), int'(shrt), int'(multi), int'(dk)};
            for (int k = 4; k >= 0; k--) if (causes[k] != 0) exp_code = codes[k];
            if (conf || skp || shrt || multi || dk) begin m_mode = 1; m_streak = 0; end
        end else if (m_mode == 1) begin
            if (clear_fault && allred) begin m_mode = 2; m_run = 0; end
        end else begin
            if (!allred) m_mode = 1;
            else begin
                m_run++;
                if (m_run >= RECOVER_CYCLES) begin m_mode = 0; exp_code = 0; end
            end
        end
        for (int i = 0; i < 3; i++) begin
            m_yrun[i] = cur[i][1] ? ((m_yrun[i] < 15) ? m_yrun[i] + 1 : 15) : 0;
            m_prev[i] = cur[i];
        end
        m_hist = 1'b1;
        exp_fault = (m_mode != 0) ? 1 : 0;
        exp_flash = exp_fault;
    endtask

    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                        input logic t, input logic w, input logic o, input logic clr);
        head1 = a; head2 = b; head3 = c; turn = t; white = w; orange = o; clear_fault = clr;
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic allred(input logic clr);
        step(R, R, R, 1'b0, 1'b0, 1'b1, clr);
    endtask

    task automatic recover_all(input string tag);
        allred(1'b1);
        repeat (RECOVER_CYCLES - 1) allred(1'b0);
        check({tag, "_recovering_fault"}, fault, 1);
        allred(1'b0);
        check({tag, "_recovered_fault"}, fault, 0);
        check({tag, "_recovered_code"}, fault_code, 0);
    endtask

    // Compare DUT against the model on every falling edge
    always @(negedge clock) begin
        if (cmp_en) begin
            check("model_fault", fault, exp_fault);
            check("model_flash", flash, exp_flash);
            check("model_code", fault_code, exp_code);
        end
    end

    initial begin
        model_reset();
        cmp_en = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_fault", fault, 0);
        check("reset_flash", flash, 1);
        check("reset_code", fault_code, 0);
        reset = 1'b0;
        allred(1'b0);
        check("flash_after_release", flash, 0);

        // legal main-road cycle
        repeat (4) step(G, R, R, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(Y, R, R, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) allred(1'b0);
        check("legal_cycle_fault", fault, 0);

        // one-sample conflict is forgiven, two latch CONFLICT
        step(G, R, R, 1'b1, 1'b0, 1'b1, 1'b0);
        step(G, R, R, 1'b0, 1'b0, 1'b1, 1'b0);
        check("single_conflict_fault", fault, 0);
        step(G, G, R, 1'b0, 1'b0, 1'b1, 1'b0);
        check("conflict_first_sample", fault, 0);
        step(G, G, R, 1'b0, 1'b0, 1'b1, 1'b0);
        check("conflict_fault", fault, 1);
        check("conflict_flash", flash, 1);
        check("conflict_code", fault_code, 1);

        // clear ignored while not all-red; green during recovery relatches
        step(R, G, R, 1'b0, 1'b0, 1'b1, 1'b1);
        check("clear_ignored", fault, 1);
        allred(1'b1);
        repeat (2) allred(1'b0);
        step(R, G, R, 1'b0, 1'b0, 1'b1, 1'b0);
        check("relatch_fault", fault, 1);
        check("relatch_code", fault_code, 1);
        recover_all("conflict");

        // skipped yellow
        repeat (2) step(G, R, R, 1'b0, 1'b0, 1'b1, 1'b0);
        allred(1'b0);
        check("skip_code", fault_code, 5);
        recover_all("skip");

        // short yellow
        repeat (2) step(G, R, R, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) step(Y, R, R, 1'b0, 1'b0, 1'b1, 1'b0);
        allred(1'b0);
        check("short_code", fault_code, 4);
        recover_all("short");

        // conflict outranks simultaneous multi-lamp
        repeat (2) step(3'b011, G, R, 1'b0, 1'b0, 1'b1, 1'b0);
        check("priority_code", fault_code, 1);
        recover_all("priority");

        // dark head
        step(R, R, OFF, 1'b0, 1'b0, 1'b1, 1'b0);
        check("dark_first_sample", fault, 0);
        step(R, R, OFF, 1'b0, 1'b0, 1'b1, 1'b0);
        check("dark_code", fault_code, 3);
        recover_all("dark");

        // pedestrian multi-lamp latched, later conflict cannot overwrite
        repeat (2) step(R, R, R, 1'b0, 1'b1, 1'b1, 1'b0);
        check("ped_multi_code", fault_code, 2);
        step(G, G, R, 1'b0, 1'b0, 1'b1, 1'b0);
        check("frozen_code", fault_code, 2);

        // asynchronous reset mid-fault
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_reset_fault", fault, 0);
        check("async_reset_code", fault_code, 0);
        check("async_reset_flash", flash, 1);
        head1 = R; head2 = R; head3 = R; turn = 1'b0; white = 1'b0; orange = 1'b1;
        clear_fault = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        allred(1'b0);
        check("flash_after_rerelease", flash, 0);
        repeat (2) allred(1'b0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
